// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI (8255) bus sequencer: bus addresses, FSM states,
// control-word bit layout and the latched transaction record.
package ppi_pkg;

  localparam logic [1:0] PPI_PORT_A = 2'b00;
  localparam logic [1:0] PPI_PORT_B = 2'b01;
  localparam logic [1:0] PPI_PORT_C = 2'b10;
  localparam logic [1:0] PPI_CTRL   = 2'b11;

  // Control word layout (mode-set form when MODE_SET_BIT=1, BSR form otherwise)
  localparam int MODE_SET_BIT = 7;
  localparam int A_MODE_MSB   = 6;
  localparam int A_MODE_LSB   = 5;
  localparam int A_DIR_BIT    = 4;
  localparam int CU_DIR_BIT   = 3;
  localparam int B_MODE_BIT   = 2;
  localparam int B_DIR_BIT    = 1;
  localparam int CL_DIR_BIT   = 0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } ppi_state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
  } ppi_txn_t;

  function automatic logic is_mode_set(input logic [7:0] cw);
    return cw[MODE_SET_BIT];
  endfunction

endpackage

// File: rtl/ppi_rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr_i, as one-hot and index.
module ppi_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Shared 8255 bus master: init write of INIT_CTRL, then round-robin timed bus cycles.
// Optional macro PPI_CTRL_SHADOW_EN keeps a copy of the last mode-set control word.
module ppi_bus_sequencer
  import ppi_pkg::*;
#(
  parameter int         N_REQ      = 2,
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 3,
  parameter int         HOLD_CYC   = 1,
  parameter logic [7:0] INIT_CTRL  = 8'h9B
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [2*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               busy,
  output logic               init_done,
  output logic               ppi_cs_n,
  output logic               ppi_rd_n,
  output logic               ppi_wr_n,
  output logic [1:0]         ppi_addr,
  output logic [7:0]         ppi_data_out,
  output logic               ppi_data_oe,
  input  logic [7:0]         ppi_data_in,
  output logic [7:0]         ctrl_shadow
);

  localparam int IDXW = $clog2(N_REQ);
  localparam logic [7:0] CNT_SETUP  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] CNT_STROBE = 8'(STROBE_CYC - 1);
  localparam logic [7:0] CNT_HOLD   = 8'(HOLD_CYC - 1);

  ppi_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  ppi_txn_t        txn_q, txn_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            is_init_q, is_init_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [N_REQ-1:0] grant;
  logic [IDXW-1:0]  gidx;
  logic             gany;
  ppi_txn_t         gtxn;

  ppi_rr_arbiter #(.N_REQ(N_REQ), .IDXW(IDXW)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  always_comb begin
    int gi;
    gi         = int'(gidx);
    gtxn.wr    = req_write[gi];
    gtxn.addr  = req_addr[2*gi +: 2];
    gtxn.wdata = req_wdata[8*gi +: 8];
  end

`ifdef PPI_CTRL_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    // Only completed mode-set writes move the shadow; BSR writes leave it alone.
    if (state_q == ST_DONE && txn_q.wr && txn_q.addr == PPI_CTRL && is_mode_set(txn_q.wdata))
      shadow_d = txn_q.wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) shadow_q <= 8'h00;
    else       shadow_q <= shadow_d;
  end

  assign ctrl_shadow = shadow_q;
`else
  assign ctrl_shadow = 8'h00;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    txn_d        = txn_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    is_init_d    = is_init_q;
    init_done_d  = init_done_q;
    rdata_d      = rdata_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_rdata    = 8'h00;
    busy         = 1'b1;
    ppi_cs_n     = 1'b1;
    ppi_rd_n     = 1'b1;
    ppi_wr_n     = 1'b1;
    ppi_addr     = 2'b00;
    ppi_data_out = 8'h00;
    ppi_data_oe  = 1'b0;

    // Address/data are held from SETUP through HOLD; only the strobe toggles.
    if (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) begin
      ppi_cs_n = 1'b0;
      ppi_addr = txn_q.addr;
      if (txn_q.wr) begin
        ppi_data_oe  = 1'b1;
        ppi_data_out = txn_q.wdata;
      end
    end

    case (state_q)
      ST_INIT: begin
        txn_d.wr    = 1'b1;
        txn_d.addr  = PPI_CTRL;
        txn_d.wdata = INIT_CTRL;
        is_init_d   = 1'b1;
        rdata_d     = 8'h00;
        cnt_d       = CNT_SETUP;
        state_d     = ST_SETUP;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (gany && init_done_q) begin
          req_ready = grant;
          txn_d     = gtxn;
          owner_d   = gidx;
          ptr_d     = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
          is_init_d = 1'b0;
          rdata_d   = 8'h00;
`ifdef PPI_CTRL_SHADOW_EN
          if (!gtxn.wr && gtxn.addr == PPI_CTRL) begin
            rdata_d = shadow_q;
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_SETUP;
            state_d = ST_SETUP;
          end
`else
          cnt_d   = CNT_SETUP;
          state_d = ST_SETUP;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_STROBE;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        ppi_rd_n = txn_q.wr;
        ppi_wr_n = !txn_q.wr;
        if (cnt_q == 8'd0) begin
          rdata_d = txn_q.wr ? 8'h00 : ppi_data_in;
          cnt_d   = CNT_HOLD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_DONE: begin
        if (is_init_q) begin
          init_done_d = 1'b1;
        end else begin
          rsp_valid[owner_q] = 1'b1;
          rsp_rdata          = rdata_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'd0;
      txn_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      is_init_q   <= 1'b0;
      init_done_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txn_q       <= txn_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      is_init_q   <= is_init_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: init write, read, write, contention, mid-cycle reset
// and (with PPI_CTRL_SHADOW_EN) shadowed control reads.
module tb_ppi_bus_sequencer;
  localparam int N = 2;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [2*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [7:0]     rsp_rdata, ppi_data_out, ppi_data_in, ctrl_shadow, rd_model;
  logic           busy, init_done, ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_data_oe;
  logic [1:0]     ppi_addr;

  always #5 CLK = ~CLK;

  // Minimal PPI model: drives read data only while CS_n and RD_n are both low.
  assign ppi_data_in = (!ppi_cs_n && !ppi_rd_n) ? rd_model : 8'hFF;

  ppi_bus_sequencer dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .init_done(init_done),
    .ppi_cs_n(ppi_cs_n), .ppi_rd_n(ppi_rd_n), .ppi_wr_n(ppi_wr_n),
    .ppi_addr(ppi_addr), .ppi_data_out(ppi_data_out), .ppi_data_oe(ppi_data_oe),
    .ppi_data_in(ppi_data_in), .ctrl_shadow(ctrl_shadow)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n_cs, n_wr, n_rd, n_oe, n_viol, n_abad, n_dbad, n_rdy;
  int gcyc[$], gwho[$], rcyc[$], rwho[$], rdat[$];

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Runs ncyc cycles from edge+1, sampling at edge+2; drop clears a requester once granted.
  task automatic observe(input int ncyc, input bit drop, input logic [1:0] ea, input logic [7:0] ed);
    logic [N-1:0] g;
    n_cs = 0; n_wr = 0; n_rd = 0; n_oe = 0; n_viol = 0; n_abad = 0; n_dbad = 0; n_rdy = 0;
    gcyc.delete(); gwho.delete(); rcyc.delete(); rwho.delete(); rdat.delete();
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (!ppi_cs_n) begin n_cs++; if (ppi_addr !== ea) n_abad++; end
      if (!ppi_wr_n) n_wr++;
      if (!ppi_rd_n) n_rd++;
      if (ppi_data_oe) begin n_oe++; if (ppi_data_out !== ed) n_dbad++; end
      if ((!ppi_rd_n && !ppi_wr_n) || ((!ppi_rd_n || !ppi_wr_n) && ppi_cs_n)) n_viol++;
      if (|(req_ready & ~req_valid)) n_rdy++;
      g = req_ready & req_valid;
      if (|g) begin gcyc.push_back(c); gwho.push_back(int'(g)); end
      if (|rsp_valid) begin rcyc.push_back(c); rwho.push_back(int'(rsp_valid)); rdat.push_back(int'(rsp_rdata)); end
      @(posedge CLK); #1;
      if (drop) req_valid = req_valid & ~g;
    end
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rd_model = 8'hA5;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cs_n", ppi_cs_n, 1);
    chk("rst_wr_rd", {ppi_wr_n, ppi_rd_n}, 2'b11);
    chk("rst_oe", ppi_data_oe, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp", rsp_valid, 0);
    RESET = 1'b0;

    // Init write of 0x9B to the control register
    observe(8, 0, 2'b11, 8'h9B);
    chk("init_cs_cyc", n_cs, 5);
    chk("init_wr_cyc", n_wr, 3);
    chk("init_rd_cyc", n_rd, 0);
    chk("init_dbad", n_dbad, 0);
    chk("init_abad", n_abad, 0);
    chk("init_rsp", rcyc.size(), 0);
    chk("init_done", init_done, 1);
    chk("idle_busy", busy, 0);
`ifdef PPI_CTRL_SHADOW_EN
    chk("init_shadow", ctrl_shadow, 8'h9B);
`else
    chk("init_shadow", ctrl_shadow, 8'h00);
`endif

    // req0 reads port A
    req_addr[1:0] = 2'b00; req_write[0] = 1'b0; req_valid = 2'b01;
    observe(12, 1, 2'b00, 8'h00);
    chk("rd_grants", gcyc.size(), 1);
    chk("rd_gwho", qat(gwho, 0), 1);
    chk("rd_lat", qat(rcyc, 0) - qat(gcyc, 0), 6);
    chk("rd_rwho", qat(rwho, 0), 1);
    chk("rd_data", qat(rdat, 0), 8'hA5);
    chk("rd_oe", n_oe, 0);
    chk("rd_rd_cyc", n_rd, 3);
    chk("rd_cs_cyc", n_cs, 5);
    chk("rd_abad", n_abad, 0);
    chk("rd_viol", n_viol, 0);

    // req1 writes 0x3C to port B
    req_addr[3:2] = 2'b01; req_write[1] = 1'b1; req_wdata[15:8] = 8'h3C; req_valid = 2'b10;
    observe(10, 1, 2'b01, 8'h3C);
    chk("wr_gwho", qat(gwho, 0), 2);
    chk("wr_lat", qat(rcyc, 0) - qat(gcyc, 0), 6);
    chk("wr_rwho", qat(rwho, 0), 2);
    chk("wr_rdata", qat(rdat, 0), 0);
    chk("wr_oe_cyc", n_oe, 5);
    chk("wr_wr_cyc", n_wr, 3);
    chk("wr_dbad", n_dbad, 0);
    chk("wr_abad", n_abad, 0);
    chk("wr_viol", n_viol, 0);

    // Contention: both held valid, reads
    req_write = 2'b00; req_addr = 4'b1000; req_valid = 2'b11;
    observe(28, 0, 2'b00, 8'h00);
    req_valid = 2'b00;
    chk("ct_grants", gcyc.size(), 4);
    chk("ct_rsps", rcyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ct_gwho%0d", k), qat(gwho, k), (k % 2 == 0) ? 1 : 2);
      chk($sformatf("ct_gcyc%0d", k), qat(gcyc, k), 7 * k);
      chk($sformatf("ct_rwho%0d", k), qat(rwho, k), (k % 2 == 0) ? 1 : 2);
      chk($sformatf("ct_rcyc%0d", k), qat(rcyc, k), 7 * k + 6);
    end
    chk("ct_viol", n_viol, 0);
    chk("ct_rdy", n_rdy, 0);

`ifdef PPI_CTRL_SHADOW_EN
    req_addr[1:0] = 2'b11; req_write[0] = 1'b1; req_wdata[7:0] = 8'h80; req_valid = 2'b01;
    observe(10, 1, 2'b11, 8'h80);
    chk("sh_wr_cyc", n_wr, 3);
    chk("sh_after_ms", ctrl_shadow, 8'h80);
    req_write[0] = 1'b0; req_valid = 2'b01;
    observe(4, 1, 2'b11, 8'h00);
    chk("sh_rd_lat", qat(rcyc, 0) - qat(gcyc, 0), 1);
    chk("sh_rd_cs", n_cs, 0);
    chk("sh_rd_data", qat(rdat, 0), 8'h80);
    req_write[0] = 1'b1; req_wdata[7:0] = 8'h05; req_valid = 2'b01;
    observe(10, 1, 2'b11, 8'h05);
    chk("sh_bsr_wr_cyc", n_wr, 3);
    chk("sh_after_bsr", ctrl_shadow, 8'h80);
`else
    req_addr[1:0] = 2'b11; req_write[0] = 1'b0; req_valid = 2'b01;
    observe(10, 1, 2'b11, 8'h00);
    chk("ctl_rd_lat", qat(rcyc, 0) - qat(gcyc, 0), 6);
    chk("ctl_rd_cs", n_cs, 5);
    chk("ctl_rd_data", qat(rdat, 0), 8'hA5);
    chk("ctl_shadow0", ctrl_shadow, 8'h00);
`endif

    // Reset asserted during STROBE of a write
    req_addr[1:0] = 2'b00; req_write[0] = 1'b1; req_wdata[7:0] = 8'h55; req_valid = 2'b01;
    #1;
    chk("mr_grant", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = 2'b00;
    @(posedge CLK); #1;
    #1;
    chk("mr_in_strobe", {ppi_cs_n, ppi_wr_n}, 2'b00);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("mr_cs_n", ppi_cs_n, 1);
    chk("mr_wr_rd", {ppi_wr_n, ppi_rd_n}, 2'b11);
    chk("mr_oe", ppi_data_oe, 0);
    chk("mr_rsp", rsp_valid, 0);
    chk("mr_init_done", init_done, 0);
    RESET = 1'b0;
    observe(9, 0, 2'b11, 8'h9B);
    chk("mr_no_rsp", rcyc.size(), 0);
    chk("mr_init_wr", n_wr, 3);
    chk("mr_init_dbad", n_dbad, 0);
    chk("mr_init_done2", init_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppi_bus_sequencer.md
Name: ppi_bus_sequencer

Overview:
- Host-side bus master that shares one 8255-style PPI bus interface among N_REQ requesters.
- Arbitrates round-robin, then generates timed CS_n/RD_n/WR_n/address/data cycles with programmable setup, strobe and hold lengths.
- After every reset, writes the mode control word INIT_CTRL before it serves any requester.
- Sits between internal clients (CPU model, test sequencers) and the chip8255 pins.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- SETUP_CYC, 1, cycles with CS_n low and address/data stable before the strobe (>=1).
- STROBE_CYC, 3, cycles with RD_n or WR_n low (>=1).
- HOLD_CYC, 1, cycles with CS_n low after the strobe is released (>=1).
- INIT_CTRL, 8'h9B, control word written to address 2'b11 after reset (mode 0, all ports input).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester transaction request.
- req_ready  out  N_REQ  one-hot grant pulse; a transfer happens when valid&ready.
- req_write  in  N_REQ  1=write, 0=read.
- req_addr  in  2*N_REQ  flattened PPI address, requester i at [2i+1:2i].
- req_wdata  in  8*N_REQ  flattened write data.
- rsp_valid  out  N_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  8  read data, valid while rsp_valid is high (0 for writes).
- busy  out  1  high in every state except IDLE.
- init_done  out  1  high once the init write has completed.
- ppi_cs_n / ppi_rd_n / ppi_wr_n  out  1 each  active-low bus strobes.
- ppi_addr  out  2  PPI address (A1:A0).
- ppi_data_out  out  8  write data to the PPI.
- ppi_data_oe  out  1  data bus drive enable.
- ppi_data_in  in  8  data bus from the PPI.
- ctrl_shadow  out  8  see Optional Feature.

Behaviour:
- Reset (synchronous, RESET high at a rising edge):
  - Outputs: cs_n/rd_n/wr_n=1, oe=0, addr=0, data_out=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, busy=1.
  - RR pointer=0; state=INIT.
  - An in-flight transaction is abandoned with no rsp_valid.
- States: INIT, IDLE, SETUP, STROBE, HOLD, DONE. A down-counter is loaded on entry to SETUP, STROBE and HOLD.
- INIT:
  - Loads an internal write of INIT_CTRL to addr 2'b11, then goes to SETUP.
  - On completion, DONE sets init_done and issues no rsp_valid.
  - req_ready stays 0 until init_done=1.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the RR pointer.
  - Grant means req_ready[g]=1 combinationally for that cycle. Latch write/addr/wdata and owner g, go to SETUP, pointer=(g+1) mod N_REQ.
  - No request: stay in IDLE.
- SETUP: cs_n=0, addr driven; for writes, oe=1 and data_out=wdata. Lasts SETUP_CYC cycles.
- STROBE: additionally rd_n=0 (read) or wr_n=0 (write) for STROBE_CYC cycles. ppi_data_in is captured at the edge that leaves STROBE.
- HOLD:
  - rd_n/wr_n=1; cs_n=0, addr and data unchanged for HOLD_CYC cycles.
  - oe stays 1 through HOLD for writes and drops entering DONE.
- DONE:
  - One cycle: cs_n=1, rsp_valid[owner]=1, rsp_rdata=captured data (0 on writes).
  - Next state IDLE; no grant is issued in DONE.
- Timing:
  - A grant edge leads to rsp_valid after SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (defaults: 6).
  - Minimum spacing between grants is that value +1.
- Bus rules: rd_n and wr_n are never low together; neither is ever low while cs_n is high.
- A requester that drops req_valid before its grant is simply skipped; no partial cycle is issued.
- Requests on addr 2'b11 pass through as ordinary cycles (mode set or BSR decided by the PPI).

Optional Feature:
- Macro: PPI_CTRL_SHADOW_EN.
- With the macro:
  - Every completed write to addr 2'b11 with data[7]=1, including the init write, updates ctrl_shadow.
  - BSR writes (data[7]=0) leave ctrl_shadow unchanged.
  - A read request to 2'b11 issues no bus cycle: IDLE goes directly to DONE and returns ctrl_shadow (latency 1).
  - ctrl_shadow resets to 0.
- Without the macro: ctrl_shadow is tied to 0, and reads of 2'b11 run a normal bus cycle.

Decomposition:
- Package ppi_pkg holds:
  - Address constants PPI_PORT_A=2'b00, PPI_PORT_B=2'b01, PPI_PORT_C=2'b10, PPI_CTRL=2'b11.
  - State enum.
  - Control-word bit positions (MODE_SET_BIT=7, A_MODE=6:5, A_DIR=4, CU_DIR=3, B_MODE=2, B_DIR=1, CL_DIR=0).
- Sub-module: ppi_rr_arbiter (valid vector, pointer -> one-hot grant, grant index).

Test Plan:
- Reset release, defaults: cycles 1-6 show the write of 8'h9B to addr 3 (wr_n low exactly 3 cycles, cs_n low 5 cycles); init_done=1; no rsp_valid pulse.
- Read: req0 reads addr 0 with ppi_data_in=8'hA5 during STROBE -> rsp_valid[0] 6 cycles after grant, rsp_rdata=8'hA5, oe never high.
- Contention: req0 and req1 held valid -> grants alternate 0,1,0,1; each spaced 7 cycles apart; rsp_valid goes to the correct owner.
- Write: req1 writes 8'h3C to addr 1 -> oe=1 and data_out=8'h3C over SETUP..HOLD, wr_n low 3 cycles, rsp_rdata=0.
- Reset mid-cycle: RESET asserted during STROBE -> next edge cs_n=wr_n=rd_n=1 and oe=0; no rsp_valid; init write repeats.
- PPI_CTRL_SHADOW_EN: write 8'h80 to addr 3, then read addr 3 -> rsp_rdata=8'h80 one cycle after grant with no cs_n activity; BSR write 8'h05 leaves shadow at 8'h80.
